// File: rtl/xfcp_resp_arbiter.sv
// rtl/xfcp_resp_arbiter.sv - round-robin packet arbiter merging downstream XFCP responses upstream
module xfcp_resp_arbiter #(
  parameter int PORTS        = 4,
  parameter int PREPEND_PORT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORTS*8-1:0] down_xfcp_in_tdata,
  input  logic [PORTS-1:0]   down_xfcp_in_tvalid,
  output logic [PORTS-1:0]   down_xfcp_in_tready,
  input  logic [PORTS-1:0]   down_xfcp_in_tlast,
  input  logic [PORTS-1:0]   down_xfcp_in_tuser,
  output logic [7:0]         up_xfcp_out_tdata,
  output logic               up_xfcp_out_tvalid,
  input  logic               up_xfcp_out_tready,
  output logic               up_xfcp_out_tlast,
  output logic               up_xfcp_out_tuser,
  output logic               grant_valid,
  output logic [3:0]         grant_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] rr_ptr;
  logic [3:0] rr_ptr_next;
  logic [3:0] grant_next;

  logic       out_free;
  logic       beat_accept;
  logic       load_hdr;

  logic       arb_found;
  logic [3:0] arb_index;
  int         arb_dist;
  int         best_dist;

  logic [7:0] sel_tdata;
  logic       sel_tvalid;
  logic       sel_tlast;
  logic       sel_tuser;

  // The output register can take a new beat when empty or being drained this cycle.
  assign out_free    = !up_xfcp_out_tvalid || up_xfcp_out_tready;
  assign load_hdr    = (state == HDR) && out_free;
  assign beat_accept = (state == DATA) && out_free && sel_tvalid;
  assign grant_valid = (state == HDR) || (state == DATA);

  // Round-robin pick: the requester with the smallest upward distance from rr_ptr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_index = '0;
    best_dist = PORTS;
    arb_dist  = 0;
    for (int i = 0; i < PORTS; i++) begin
      if (down_xfcp_in_tvalid[i]) begin
        arb_dist = (i + PORTS - int'(rr_ptr)) % PORTS;
        if (arb_dist < best_dist) begin
          best_dist = arb_dist;
          arb_found = 1'b1;
          arb_index = 4'(i);
        end
      end
    end
  end

  // Select the granted port's stream.
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index == 4'(i)) begin
        sel_tdata  = down_xfcp_in_tdata[i*8 +: 8];
        sel_tvalid = down_xfcp_in_tvalid[i];
        sel_tlast  = down_xfcp_in_tlast[i];
        sel_tuser  = down_xfcp_in_tuser[i];
      end
    end
  end

  // Only the granted port sees ready, and only while payload is flowing.
  always_comb begin
    down_xfcp_in_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      down_xfcp_in_tready[i] = (state == DATA) && (grant_index == 4'(i)) && out_free;
    end
  end

  // Next-state logic: grant is held from arbitration until the tlast beat is accepted.
  always_comb begin
    state_next  = state;
    grant_next  = grant_index;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_next = arb_index;
          state_next = (PREPEND_PORT != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (out_free) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (beat_accept && sel_tlast) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_index == 4'(PORTS - 1)) ? 4'd0 : grant_index + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_index <= '0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_next;
      grant_index <= grant_next;
      rr_ptr      <= rr_ptr_next;
    end
  end

  // Output register: loads the header or an accepted beat, holds while stalled upstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_xfcp_out_tdata  <= '0;
      up_xfcp_out_tvalid <= 1'b0;
      up_xfcp_out_tlast  <= 1'b0;
      up_xfcp_out_tuser  <= 1'b0;
    end else if (out_free) begin
      if (load_hdr) begin
        up_xfcp_out_tdata  <= {4'b0000, grant_index};
        up_xfcp_out_tvalid <= 1'b1;
        up_xfcp_out_tlast  <= 1'b0;
        up_xfcp_out_tuser  <= 1'b0;
      end else if (beat_accept) begin
        up_xfcp_out_tdata  <= sel_tdata;
        up_xfcp_out_tvalid <= 1'b1;
        up_xfcp_out_tlast  <= sel_tlast;
        up_xfcp_out_tuser  <= sel_tuser;
      end else begin
        up_xfcp_out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xfcp_resp_arbiter.sv
// tb/tb_xfcp_resp_arbiter.sv - self-checking bench for xfcp_resp_arbiter
module tb_xfcp_resp_arbiter;

  localparam int PORTS = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PORTS*8-1:0] down_tdata;
  logic [PORTS-1:0]   down_tvalid;
  logic [PORTS-1:0]   down_tready;
  logic [PORTS-1:0]   down_tlast;
  logic [PORTS-1:0]   down_tuser;
  logic [7:0]         up_tdata;
  logic               up_tvalid;
  logic               up_tready;
  logic               up_tlast;
  logic               up_tuser;
  logic               grant_valid;
  logic [3:0]         grant_index;

  always #5 clk = ~clk;

  xfcp_resp_arbiter #(
    .PORTS(PORTS),
    .PREPEND_PORT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .down_xfcp_in_tdata(down_tdata),
    .down_xfcp_in_tvalid(down_tvalid),
    .down_xfcp_in_tready(down_tready),
    .down_xfcp_in_tlast(down_tlast),
    .down_xfcp_in_tuser(down_tuser),
    .up_xfcp_out_tdata(up_tdata),
    .up_xfcp_out_tvalid(up_tvalid),
    .up_xfcp_out_tready(up_tready),
    .up_xfcp_out_tlast(up_tlast),
    .up_xfcp_out_tuser(up_tuser),
    .grant_valid(grant_valid),
    .grant_index(grant_index)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // beats are {tuser, tlast, tdata}
  logic [9:0] src_q [PORTS][$];
  logic [9:0] exp_q [$];
  logic [9:0] obs_q [$];
  int         pause_cnt [PORTS];
  int         pause_at  [PORTS];
  int         acc_cnt   [PORTS];
  bit         src_in_pkt [PORTS];
  bit         rand_ready;
  bit         rand_pause;
  int         model_ptr;
  bit         obs_in_pkt;
  logic [3:0] last_hdr;
  bit         prev_stalled;
  logic [9:0] prev_out;
  int         first_valid_cyc;
  logic [PORTS-1:0] acc_mask;

  function automatic bit all_empty();
    for (int i = 0; i < PORTS; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    logic [9:0] b;
    for (int i = 0; i < PORTS; i++) begin
      if (rand_pause && src_in_pkt[i] && pause_cnt[i] == 0 && $urandom_range(0, 7) == 0)
        pause_cnt[i] = $urandom_range(1, 4);
      if (pause_cnt[i] > 0) begin
        down_tvalid[i] = 1'b0;
        pause_cnt[i]--;
      end else begin
        down_tvalid[i] = (src_q[i].size() > 0);
      end
      b = (src_q[i].size() > 0) ? src_q[i][0] : 10'h000;
      down_tdata[i*8 +: 8] = b[7:0];
      down_tlast[i]        = b[8];
      down_tuser[i]        = b[9];
    end
    up_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    logic [9:0] b;
    @(negedge clk);
    if (up_tvalid && up_tready) begin
      obs_q.push_back({up_tuser, up_tlast, up_tdata});
      if (!obs_in_pkt) begin
        last_hdr   = up_tdata[3:0];
        obs_in_pkt = 1'b1;
      end else if (up_tlast) begin
        obs_in_pkt = 1'b0;
      end
    end
    if (up_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stalled) begin
      checks++;
      if ({up_tuser, up_tlast, up_tdata} !== prev_out || up_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold: got v=%b %h required v=1 %h", up_tvalid, {up_tuser, up_tlast, up_tdata}, prev_out);
      end
    end
    prev_stalled = up_tvalid && !up_tready;
    prev_out     = {up_tuser, up_tlast, up_tdata};
    if (|down_tready) begin
      checks++;
      if (down_tready !== (4'b0001 << last_hdr)) begin
        failures++;
        $display("FAIL tready_owner: got %b required %b", down_tready, 4'b0001 << last_hdr);
      end
    end
    acc_mask = down_tvalid & down_tready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < PORTS; i++) begin
      if (acc_mask[i]) begin
        b = src_q[i].pop_front();
        acc_cnt[i]++;
        src_in_pkt[i] = !b[8];
        if (acc_cnt[i] == pause_at[i]) begin
          pause_cnt[i] = 5;
          pause_at[i]  = -1;
        end
      end
    end
    drive_inputs();
  endtask

  // Reference: whole packets in round-robin order over non-empty ports, each preceded by its port byte.
  task automatic build_expected();
    int pos [PORTS];
    int p;
    int c;
    bit any;
    logic [9:0] b;
    exp_q.delete();
    for (int i = 0; i < PORTS; i++) pos[i] = 0;
    for (int guard = 0; guard < 500; guard++) begin
      any = 1'b0;
      p   = 0;
      for (int k = 0; k < PORTS; k++) begin
        c = (model_ptr + k) % PORTS;
        if (!any && pos[c] < src_q[c].size()) begin
          any = 1'b1;
          p   = c;
        end
      end
      if (!any) break;
      exp_q.push_back({2'b00, 8'(p)});
      do begin
        b = src_q[p][pos[p]];
        pos[p]++;
        exp_q.push_back(b);
      end while (!b[8] && pos[p] < src_q[p].size());
      model_ptr = (p + 1) % PORTS;
    end
  endtask

  task automatic run_traffic(input string name, input int max_cycles);
    int n;
    bit done;
    obs_q.delete();
    build_expected();
    drive_inputs();
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cycles) begin
      step();
      n++;
      if (obs_q.size() >= exp_q.size() && all_empty()) done = 1'b1;
    end
    repeat (4) step();
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: got %0d beats required %0d within %0d cycles", name, obs_q.size(), exp_q.size(), max_cycles);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_beat%0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({up_tvalid, up_tdata, up_tlast, up_tuser, grant_valid, grant_index, down_tready} !== 20'h0) begin
      failures++;
      $display("FAIL %s: got v=%b d=%h l=%b u=%b gv=%b gi=%h rdy=%b required all zero", name,
               up_tvalid, up_tdata, up_tlast, up_tuser, grant_valid, grant_index, down_tready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    rand_ready = 1'b0;
    rand_pause = 1'b0;
    model_ptr  = 0;
    obs_in_pkt = 1'b0;
    last_hdr   = '0;
    prev_stalled = 1'b0;
    prev_out   = '0;
    first_valid_cyc = -1;
    for (int i = 0; i < PORTS; i++) begin
      src_q[i].delete();
      pause_cnt[i]  = 0;
      pause_at[i]   = -1;
      acc_cnt[i]    = 0;
      src_in_pkt[i] = 1'b0;
    end
    drive_inputs();
    repeat (3) step();
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) step();
    check_idle_outputs("idle_no_request");
  endtask

  task automatic test_fairness();
    for (int i = 0; i < PORTS; i++) begin
      for (int k = 0; k < 2; k++) begin
        src_q[i].push_back({2'b00, 4'(i), 4'(2*k+1)});
        src_q[i].push_back({2'b01, 4'(i), 4'(2*k+2)});
      end
    end
    run_traffic("fairness", 200);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs_q.size() <= 3*k || obs_q[3*k] !== {2'b00, 8'(k % 4)}) begin
        failures++;
        $display("FAIL fairness_hdr%0d: got %h required %h", k,
                 (obs_q.size() > 3*k) ? obs_q[3*k] : 10'h3FF, {2'b00, 8'(k % 4)});
      end
    end
  endtask

  task automatic test_mid_stall();
    for (int k = 1; k <= 6; k++) src_q[0].push_back({1'b0, (k == 6), 8'(k)});
    src_q[3].push_back(10'h031);
    src_q[3].push_back(10'h132);
    pause_at[0] = acc_cnt[0] + 2;
    run_traffic("mid_stall", 200);
    checks++;
    if (obs_q.size() < 8 || obs_q[7] !== 10'h003) begin
      failures++;
      $display("FAIL mid_stall_next_grant: got %h required %h", (obs_q.size() >= 8) ? obs_q[7] : 10'h3FF, 10'h003);
    end
  endtask

  task automatic test_single_packet();
    int start_cyc;
    src_q[2].push_back(10'h011);
    src_q[2].push_back(10'h022);
    src_q[2].push_back(10'h133);
    first_valid_cyc = -1;
    start_cyc = cyc;
    run_traffic("single", 100);
    checks++;
    if (first_valid_cyc - start_cyc != 2) begin
      failures++;
      $display("FAIL single_latency: got %0d required 2", first_valid_cyc - start_cyc);
    end
    checks++;
    if (obs_q.size() != 4 || obs_q[0] !== 10'h002 || obs_q[3] !== 10'h133) begin
      failures++;
      $display("FAIL single_frame: got size %0d required 4 with header 002 and last 133", obs_q.size());
    end
    src_q[0].push_back(10'h144);
    src_q[3].push_back(10'h155);
    run_traffic("rr_after_port2", 100);
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 10'h003) begin
      failures++;
      $display("FAIL rr_ptr_after_port2: got %h required %h", (obs_q.size() > 0) ? obs_q[0] : 10'h3FF, 10'h003);
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    base = acc_cnt[1];
    for (int k = 1; k <= 5; k++) src_q[1].push_back({1'b0, (k == 5), 8'(8'h50 + k)});
    drive_inputs();
    for (int n = 0; n < 40 && acc_cnt[1] < base + 2; n++) step();
    checks++;
    if (acc_cnt[1] < base + 2) begin
      failures++;
      $display("FAIL reset_mid_setup: got %0d beats required 2", acc_cnt[1] - base);
    end
    rst_n = 1'b0;
    step();
    check_idle_outputs("reset_mid_packet");
    obs_in_pkt   = 1'b0;
    prev_stalled = 1'b0;
    model_ptr    = 0;
    src_q[0].push_back(10'h10F);
    rst_n = 1'b1;
    run_traffic("after_reset", 100);
    checks++;
    if (obs_q.size() < 3 || obs_q[0] !== 10'h000 || obs_q[2] !== 10'h001) begin
      failures++;
      $display("FAIL reset_regrant: got size %0d required headers 000 then 001 at beat 2", obs_q.size());
    end
  endtask

  task automatic test_tuser_single();
    src_q[3].push_back(10'h3AA);
    run_traffic("tuser_single", 50);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 10'h003 || obs_q[1] !== 10'h3AA) begin
      failures++;
      $display("FAIL tuser_single_frame: got size %0d required 003 then 3AA", obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    rand_ready = 1'b1;
    for (int k = 0; k < 16; k++) src_q[1].push_back({1'b0, (k == 15), 8'($urandom_range(0, 255))});
    run_traffic("backpressure", 400);
    checks++;
    if (obs_q.size() != 17 || obs_q[0] !== 10'h001) begin
      failures++;
      $display("FAIL backpressure_frame: got size %0d required 17 with header 001", obs_q.size());
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_random();
    int npkt;
    int len;
    rand_ready = 1'b1;
    rand_pause = 1'b1;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < PORTS; i++) begin
        npkt = $urandom_range(0, 2);
        for (int p = 0; p < npkt; p++) begin
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++)
            src_q[i].push_back({1'($urandom_range(0, 1)), (k == len - 1), 8'($urandom_range(0, 255))});
        end
      end
      run_traffic("random", 2000);
    end
    rand_ready = 1'b0;
    rand_pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_mid_stall();
    test_single_packet();
    test_reset_mid_packet();
    test_tuser_single();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
